exp4_unidade_controle: RTL



---
 rtl/exp4_unidade_controle.sv | 132 +++++++++++++
 1 files changed

// File: rtl/exp4_unidade_controle.sv
// Moore control unit for the Experiment 4 ROM comparison game (16 moves, hit/miss/timeout ends).
// Optional espera timeout is built only when EXP4_UC_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module exp4_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMO     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERROU   = 4'hE
  } t_estado;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (1 << 20)) begin : g_param_chk
    $error("TIMEOUT_CYCLES out of range 2..2^20");
  end

  t_estado r_estado;
  t_estado w_prox;
  logic    r_jog_d;
  logic    w_jog_edge;
  logic    w_tc;
  logic    r_zeraC, r_contaC, r_zeraR, r_registraR;
  logic    r_pronto, r_acertou, r_errou;

  assign w_jog_edge = jogada & ~r_jog_d;

`ifdef EXP4_UC_TIMEOUT_EN
  logic [19:0] r_cnt;
  logic        r_timeout;

  // Counts cycles spent in espera; any other state holds it at zero, so entry clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (r_estado != ESPERA)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 20'd1;
  end

  assign w_tc    = (r_cnt == 20'(TIMEOUT_CYCLES - 1));
  assign timeout = r_timeout;
`else
  assign w_tc    = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:    if (iniciar) w_prox = PREPARACAO;
      PREPARACAO: w_prox = ESPERA;
      ESPERA: begin
        if (w_jog_edge)  w_prox = REGISTRA;
        else if (w_tc)   w_prox = FIM_TIMEOUT;
      end
      REGISTRA:   w_prox = COMPARACAO;
      COMPARACAO: begin
        if (!igual)      w_prox = FIM_ERROU;
        else if (fimC)   w_prox = FIM_ACERTOU;
        else             w_prox = PROXIMO;
      end
      PROXIMO:    w_prox = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: if (iniciar) w_prox = PREPARACAO;
      default:    w_prox = INICIAL;
    endcase
  end

  // Outputs are decoded from the next state so each register equals the decode of r_estado.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= INICIAL;
      r_jog_d     <= 1'b0;
      r_zeraC     <= 1'b0;
      r_contaC    <= 1'b0;
      r_zeraR     <= 1'b0;
      r_registraR <= 1'b0;
      r_pronto    <= 1'b0;
      r_acertou   <= 1'b0;
      r_errou     <= 1'b0;
`ifdef EXP4_UC_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_estado    <= w_prox;
      r_jog_d     <= jogada;
      r_zeraC     <= (w_prox == PREPARACAO);
      r_zeraR     <= (w_prox == PREPARACAO);
      r_contaC    <= (w_prox == PROXIMO);
      r_registraR <= (w_prox == REGISTRA);
      r_pronto    <= (w_prox == FIM_ACERTOU) || (w_prox == FIM_ERROU) || (w_prox == FIM_TIMEOUT);
      r_acertou   <= (w_prox == FIM_ACERTOU);
      r_errou     <= (w_prox == FIM_ERROU) || (w_prox == FIM_TIMEOUT);
`ifdef EXP4_UC_TIMEOUT_EN
      r_timeout   <= (w_prox == FIM_TIMEOUT);
`endif
    end
  end

  assign zeraC     = r_zeraC;
  assign contaC    = r_contaC;
  assign zeraR     = r_zeraR;
  assign registraR = r_registraR;
  assign pronto    = r_pronto;
  assign acertou   = r_acertou;
  assign errou     = r_errou;
  assign db_estado = r_estado;

endmodule
